ansi_key_decoder: RTL

//  Input-side counterpart of the ANSI terminal writer. Parses the raw stdin byte stream
//  (one byte per clk from io) into key events and cursor-position reports (ESC[r;cR).
//  The CPR is the reply to ESC[6n, which lets the controller learn n_row/n_col at run time.

---
 rtl/ansi_pkg.sv | 45 ++++
 rtl/ansi_key_decoder_csi_param_acc.sv | 37 +++
 rtl/ansi_key_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ansi_pkg.sv
// ansi_pkg: definitions shared by the ANSI terminal writer and the key decoder.
//   - KEY_* event codes reported on key_code
//   - byte constants for the control characters both sides use
//   - decoder FSM state encoding
//   - sat_dec_acc: one step of a saturating decimal accumulator
package ansi_pkg;

  localparam logic [3:0] KEY_NONE      = 4'd0;
  localparam logic [3:0] KEY_CHAR      = 4'd1;
  localparam logic [3:0] KEY_SPACE     = 4'd2;
  localparam logic [3:0] KEY_ENTER     = 4'd3;
  localparam logic [3:0] KEY_UP        = 4'd4;
  localparam logic [3:0] KEY_DOWN      = 4'd5;
  localparam logic [3:0] KEY_RIGHT     = 4'd6;
  localparam logic [3:0] KEY_LEFT      = 4'd7;
  localparam logic [3:0] KEY_ESC       = 4'd8;
  localparam logic [3:0] KEY_ALT       = 4'd9;
  localparam logic [3:0] KEY_DELETE    = 4'd10;
  localparam logic [3:0] KEY_CSI_OTHER = 4'd11;
  localparam logic [3:0] KEY_EOF       = 4'd12;

  localparam logic [7:0] BYTE_ESC      = 8'h1B;
  localparam logic [7:0] BYTE_SPACE    = 8'h20;
  localparam logic [7:0] BYTE_CR       = 8'h0D;
  localparam logic [7:0] BYTE_LF       = 8'h0A;
  localparam logic [7:0] BYTE_EOF      = 8'hFF;
  localparam logic [7:0] BYTE_LBRACKET = 8'h5B;
  localparam logic [7:0] BYTE_SEMI     = 8'h3B;
  localparam logic [7:0] BYTE_TILDE    = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ESC      = 2'd1,
    ST_CSI      = 2'd2,
    ST_PEND_EOF = 2'd3
  } dec_state_t;

  // p*10 + d, saturated at 255. 12 bits holds the worst case 255*10+9.
  function automatic logic [7:0] sat_dec_acc(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] s;
    s = ({4'b0, p} * 12'd10) + {8'b0, d};
    return (s > 12'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/ansi_key_decoder_csi_param_acc.sv
// csi_param_acc: collects the numeric parameters of a CSI sequence.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      start of a new CSI sequence: zero p0/p1/pidx
//   digit_stb  digit in 'digit' belongs to parameter pidx
//   digit      decimal digit value 0..9
//   semi_stb   ';' seen: advance to next parameter (saturates at 2)
//   p0, p1     first two parameters, each saturated at 255
//   pidx       current parameter index; 2 means "beyond p1, discard"
module csi_param_acc
  import ansi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       digit_stb,
  input  logic [3:0] digit,
  input  logic       semi_stb,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [1:0] pidx
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      p0   <= '0;
      p1   <= '0;
      pidx <= '0;
    end else if (digit_stb) begin
      if (pidx == 2'd0)      p0 <= sat_dec_acc(p0, digit);
      else if (pidx == 2'd1) p1 <= sat_dec_acc(p1, digit);
    end else if (semi_stb && pidx != 2'd2) begin
      pidx <= pidx + 2'd1;
    end
  end

endmodule

// File: rtl/ansi_key_decoder.sv
// ansi_key_decoder: turns the raw stdin byte stream into key events and
// cursor-position reports (ESC[r;cR, the reply to ESC[6n).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in_byte valid this cycle (always accepted)
//   in_byte    raw byte; 8'hFF is EOF
//   key_valid  one-cycle pulse, key_code/key_char valid
//   key_code   KEY_* code
//   key_char   byte for CHAR/ALT, final byte for CSI_OTHER, else 0
//   cpr_valid  one-cycle pulse, cpr_row/cpr_col valid (held between pulses)
//   cpr_row    reported row, saturated at 255
//   cpr_col    reported column, saturated at 255
//   seq_err    one-cycle pulse, malformed sequence dropped
module ansi_key_decoder
  import ansi_pkg::*;
#(
  parameter int unsigned ESC_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] key_char,
  output logic       cpr_valid,
  output logic [7:0] cpr_row,
  output logic [7:0] cpr_col,
  output logic       seq_err
);

  localparam int unsigned TW = $clog2(ESC_TIMEOUT + 1);

  dec_state_t    state;
  logic [TW-1:0] timer;

  logic       acc_clear;
  logic       digit_stb;
  logic       semi_stb;
  logic [7:0] p0;
  logic [7:0] p1;
  logic [1:0] pidx;

  // Accumulator strobes are decoded from the current state so the
  // parameters are updated on the same edge that consumes the byte.
  always_comb begin
    acc_clear = 1'b0;
    digit_stb = 1'b0;
    semi_stb  = 1'b0;
    if (in_valid) begin
      if (state == ST_ESC) acc_clear = (in_byte == BYTE_LBRACKET);
      if (state == ST_CSI) begin
        digit_stb = (in_byte >= 8'h30) && (in_byte <= 8'h39);
        semi_stb  = (in_byte == BYTE_SEMI);
      end
    end
  end

  csi_param_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .digit_stb (digit_stb),
    .digit     (in_byte[3:0]),
    .semi_stb  (semi_stb),
    .p0        (p0),
    .p1        (p1),
    .pidx      (pidx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      key_valid <= 1'b0;
      key_code  <= KEY_NONE;
      key_char  <= '0;
      cpr_valid <= 1'b0;
      cpr_row   <= '0;
      cpr_col   <= '0;
      seq_err   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_code  <= KEY_NONE;
      key_char  <= '0;
      cpr_valid <= 1'b0;
      seq_err   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          timer <= '0;
          if (in_valid) begin
            if (in_byte == BYTE_ESC) begin
              state <= ST_ESC;
            end else if (in_byte == BYTE_SPACE) begin
              key_valid <= 1'b1;
              key_code  <= KEY_SPACE;
            end else if (in_byte == BYTE_CR || in_byte == BYTE_LF) begin
              key_valid <= 1'b1;
              key_code  <= KEY_ENTER;
            end else if (in_byte == BYTE_EOF) begin
              key_valid <= 1'b1;
              key_code  <= KEY_EOF;
            end else if (in_byte >= 8'h21 && in_byte <= 8'h7E) begin
              key_valid <= 1'b1;
              key_code  <= KEY_CHAR;
              key_char  <= in_byte;
            end
          end
        end

        ST_ESC: begin
          // An arriving byte takes priority over an expiring timer.
          if (in_valid) begin
            timer <= '0;
            if (in_byte == BYTE_LBRACKET) begin
              state <= ST_CSI;
            end else if (in_byte == BYTE_ESC) begin
              key_valid <= 1'b1;
              key_code  <= KEY_ESC;
            end else if (in_byte == BYTE_EOF) begin
              key_valid <= 1'b1;
              key_code  <= KEY_EOF;
              state     <= ST_IDLE;
            end else begin
              key_valid <= 1'b1;
              key_code  <= KEY_ALT;
              key_char  <= in_byte;
              state     <= ST_IDLE;
            end
          end else if (timer == TW'(ESC_TIMEOUT - 1)) begin
            key_valid <= 1'b1;
            key_code  <= KEY_ESC;
            timer     <= '0;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_CSI: begin
          if (in_valid) begin
            if ((in_byte >= 8'h30 && in_byte <= 8'h39) || in_byte == BYTE_SEMI) begin
              // parameter bytes are consumed by the accumulator
            end else if (in_byte >= 8'h40 && in_byte <= 8'h7E) begin
              state <= ST_IDLE;
              if (in_byte == 8'h41) begin
                key_valid <= 1'b1;
                key_code  <= KEY_UP;
              end else if (in_byte == 8'h42) begin
                key_valid <= 1'b1;
                key_code  <= KEY_DOWN;
              end else if (in_byte == 8'h43) begin
                key_valid <= 1'b1;
                key_code  <= KEY_RIGHT;
              end else if (in_byte == 8'h44) begin
                key_valid <= 1'b1;
                key_code  <= KEY_LEFT;
              end else if (in_byte == BYTE_TILDE && p0 == 8'd3) begin
                key_valid <= 1'b1;
                key_code  <= KEY_DELETE;
              end else if (in_byte == 8'h52 && pidx != 2'd0) begin
                cpr_valid <= 1'b1;
                cpr_row   <= p0;
                cpr_col   <= p1;
              end else begin
                key_valid <= 1'b1;
                key_code  <= KEY_CSI_OTHER;
                key_char  <= in_byte;
              end
            end else if (in_byte == BYTE_ESC) begin
              seq_err <= 1'b1;
              timer   <= '0;
              state   <= ST_ESC;
            end else if (in_byte == BYTE_EOF) begin
              // Error and EOF cannot share a cycle; the EOF waits one cycle.
              seq_err <= 1'b1;
              state   <= ST_PEND_EOF;
            end else begin
              seq_err <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end

        ST_PEND_EOF: begin
          key_valid <= 1'b1;
          key_code  <= KEY_EOF;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
